// File: rtl/aap_pkg.sv
// Shared types and defaults for the AAP instruction fetch unit.
// Holds the fetch FSM encoding and instruction-format constants.
package aap_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_LO,
      S_HI,
      S_OUT
   } state_t;

   localparam int PC_W_DEF      = 16;
   localparam int RESET_PC_DEF  = 0;
   localparam int INSN_LONG_BIT = 15;

endpackage

// File: rtl/aap_fetch_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input,
// and the valid/ready handshake towards the decoder.
interface aap_fetch_if
   import aap_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) ();

   logic            imem_rd;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;

   logic            branch_valid;
   logic [PC_W-1:0] branch_target;

   logic            dec_ready;
   logic            fetch_valid;
   logic [31:0]     fetchoutput;
   logic [PC_W-1:0] fetch_pc;
   logic            fetch_long;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_rdata,
      input  branch_valid,
      input  branch_target,
      input  dec_ready,
      output fetch_valid,
      output fetchoutput,
      output fetch_pc,
      output fetch_long
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_rdata,
      output branch_valid,
      output branch_target,
      output dec_ready,
      input  fetch_valid,
      input  fetchoutput,
      input  fetch_pc,
      input  fetch_long
   );

endinterface

// File: rtl/aap_fetch.sv
// AAP fetch unit: reads 16/32-bit instructions from a 1-cycle RAM
// and offers them to the decoder, with branch redirect support.
module aap_fetch
   import aap_pkg::*;
#(
   parameter int PC_W     = PC_W_DEF,
   parameter int RESET_PC = RESET_PC_DEF
) (
   input logic         CLOCK_50,
   input logic         reset,
   aap_fetch_if.master bus
);

   state_t          state;
   state_t          state_n;
   logic [PC_W-1:0] pc;
   logic [15:0]     word_lo;
   logic [15:0]     word_hi;
   logic            out_valid;
   logic [PC_W-1:0] out_pc;
   logic            out_long;
   logic            rd;
   logic [PC_W-1:0] addr;
   logic            is_long;

   assign is_long = bus.imem_rdata[INSN_LONG_BIT];

   // Next state and memory strobe; a redirect always restarts at S_REQ
   always_comb begin
      state_n = state;
      rd      = 1'b0;
      addr    = '0;
      unique case (state)
         S_IDLE: state_n = S_REQ;
         S_REQ: begin
            rd      = 1'b1;
            addr    = pc;
            state_n = S_LO;
         end
         S_LO: begin
            if (is_long) begin
               rd      = !bus.branch_valid;
               addr    = bus.branch_valid ? '0 : pc + PC_W'(1);
               state_n = S_HI;
            end else begin
               state_n = S_OUT;
            end
         end
         S_HI: state_n = S_OUT;
         S_OUT: begin
            if (bus.dec_ready) state_n = S_REQ;
         end
         default: state_n = S_IDLE;
      endcase
      if (bus.branch_valid) state_n = S_REQ;
   end

   // State, pc and registered decoder-side outputs
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         pc        <= PC_W'(RESET_PC);
         word_lo   <= '0;
         word_hi   <= '0;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_long  <= 1'b0;
      end else begin
         state <= state_n;
         if (bus.branch_valid) begin
            pc        <= bus.branch_target;
            out_valid <= 1'b0;
         end else begin
            unique case (state)
               S_LO: begin
                  word_lo <= bus.imem_rdata;
                  out_pc  <= pc;
                  if (!is_long) begin
                     word_hi   <= '0;
                     out_long  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
               S_HI: begin
                  word_hi   <= bus.imem_rdata;
                  out_long  <= 1'b1;
                  out_valid <= 1'b1;
               end
               S_OUT: begin
                  if (bus.dec_ready) begin
                     out_valid <= 1'b0;
                     pc <= pc + (out_long ? PC_W'(2) : PC_W'(1));
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.imem_rd     = rd;
   assign bus.imem_addr   = addr;
   assign bus.fetch_valid = out_valid;
   assign bus.fetchoutput = {word_hi, word_lo};
   assign bus.fetch_pc    = out_pc;
   assign bus.fetch_long  = out_long;

endmodule

// File: tb/tb_aap_fetch.sv
// Directed bench for aap_fetch: 16-bit instance plus a PC_W=4
// instance for address wrap, each with a 1-cycle memory model.
module tb_aap_fetch;

   logic CLOCK_50;
   logic reset;
   logic rst4;

   int n_chk;
   int n_fail;

   logic [15:0] mem  [256];
   logic [15:0] mem4 [16];

   aap_fetch_if #(.PC_W(16)) bus ();
   aap_fetch_if #(.PC_W(4))  bus4 ();

   aap_fetch #(.PC_W(16), .RESET_PC(0)) u_dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   aap_fetch #(.PC_W(4), .RESET_PC(15)) u_dut4 (
      .CLOCK_50 (CLOCK_50),
      .reset    (rst4),
      .bus      (bus4)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // aap_imem_model: synchronous RAM, data one cycle after the strobe
   always @(posedge CLOCK_50) begin : aap_imem_model
      if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr[7:0]];
      if (bus4.imem_rd) bus4.imem_rdata <= mem4[bus4.imem_addr];
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLOCK_50);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
      mem[0]    = 16'h0123;
      mem[1]    = 16'h8A00;
      mem[2]    = 16'h1234;
      mem[3]    = 16'h8555;
      mem[4]    = 16'hDEAD;
      mem[5]    = 16'h0055;
      mem[8'h40] = 16'h0042;
      mem[8'h41] = 16'h8777;
      mem[8'h42] = 16'hBEEF;
      mem4[15]  = 16'h8001;
      mem4[0]   = 16'h00FF;
      mem4[1]   = 16'h0011;

      reset              = 1'b0;
      rst4               = 1'b0;
      bus.branch_valid   = 1'b0;
      bus.branch_target  = '0;
      bus.dec_ready      = 1'b1;
      bus4.branch_valid  = 1'b0;
      bus4.branch_target = '0;
      bus4.dec_ready     = 1'b1;

      step();
      step();
      check("rst_valid", bus.fetch_valid, 0);
      check("rst_out", bus.fetchoutput, 0);
      check("rst_pc", bus.fetch_pc, 0);
      check("rst_long", bus.fetch_long, 0);
      check("rst_rd", bus.imem_rd, 0);
      check("rst_addr", bus.imem_addr, 0);

      reset = 1'b1;
      #1;
      check("idle_rd", bus.imem_rd, 0);
      step();
      check("c2_rd", bus.imem_rd, 1);
      check("c2_addr", bus.imem_addr, 0);
      step();
      check("c3_rd", bus.imem_rd, 0);
      check("c3_valid", bus.fetch_valid, 0);
      step();
      check("c4_valid", bus.fetch_valid, 1);
      check("c4_out", bus.fetchoutput, 32'h0000_0123);
      check("c4_long", bus.fetch_long, 0);
      check("c4_pc", bus.fetch_pc, 0);

      step();
      check("l_req_addr", bus.imem_addr, 1);
      check("l_req_valid", bus.fetch_valid, 0);
      step();
      check("l_lo_rd", bus.imem_rd, 1);
      check("l_lo_addr", bus.imem_addr, 2);
      step();
      check("l_hi_rd", bus.imem_rd, 0);
      step();
      check("l_valid", bus.fetch_valid, 1);
      check("l_out", bus.fetchoutput, 32'h1234_8A00);
      check("l_long", bus.fetch_long, 1);
      check("l_pc", bus.fetch_pc, 1);

      bus.dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_valid", bus.fetch_valid, 1);
         check("hold_out", bus.fetchoutput, 32'h1234_8A00);
         check("hold_pc", bus.fetch_pc, 1);
         check("hold_rd", bus.imem_rd, 0);
      end
      bus.dec_ready = 1'b1;
      step();
      check("next_rd", bus.imem_rd, 1);
      check("next_addr", bus.imem_addr, 3);
      check("next_valid", bus.fetch_valid, 0);
      step();
      check("b_lo_addr", bus.imem_addr, 4);
      step();
      check("b_hi_rd", bus.imem_rd, 0);
      bus.branch_valid  = 1'b1;
      bus.branch_target = 16'h0040;
      step();
      bus.branch_valid = 1'b0;
      check("b_req_rd", bus.imem_rd, 1);
      check("b_req_addr", bus.imem_addr, 16'h0040);
      check("b_req_valid", bus.fetch_valid, 0);
      step();
      check("b_lo_valid", bus.fetch_valid, 0);
      step();
      check("b_valid", bus.fetch_valid, 1);
      check("b_out", bus.fetchoutput, 32'h0000_0042);
      check("b_pc", bus.fetch_pc, 16'h0040);

      step();
      check("r_req_addr", bus.imem_addr, 16'h0041);
      step();
      check("r_lo_addr", bus.imem_addr, 16'h0042);
      reset = 1'b0;
      #1;
      check("r_rd", bus.imem_rd, 0);
      check("r_addr", bus.imem_addr, 0);
      check("r_valid", bus.fetch_valid, 0);
      check("r_out", bus.fetchoutput, 0);
      check("r_long", bus.fetch_long, 0);
      check("r_pc", bus.fetch_pc, 0);
      step();
      step();
      reset = 1'b1;
      #1;
      check("r_idle_rd", bus.imem_rd, 0);
      step();
      check("r_req_rd", bus.imem_rd, 1);
      check("r_first_addr", bus.imem_addr, 0);
      step();
      step();
      check("bd_valid", bus.fetch_valid, 1);
      check("bd_out", bus.fetchoutput, 32'h0000_0123);
      bus.branch_valid  = 1'b1;
      bus.branch_target = 16'h0005;
      step();
      bus.branch_valid = 1'b0;
      check("bd_addr", bus.imem_addr, 16'h0005);
      check("bd_drop", bus.fetch_valid, 0);
      step();
      step();
      check("bd_out2", bus.fetchoutput, 32'h0000_0055);
      check("bd_pc2", bus.fetch_pc, 16'h0005);
      check("bd_long2", bus.fetch_long, 0);

      rst4 = 1'b1;
      step();
      check("w_req_addr", bus4.imem_addr, 15);
      check("w_req_rd", bus4.imem_rd, 1);
      step();
      check("w_lo_rd", bus4.imem_rd, 1);
      check("w_lo_addr", bus4.imem_addr, 0);
      step();
      step();
      check("w_valid", bus4.fetch_valid, 1);
      check("w_out", bus4.fetchoutput, 32'h00FF_8001);
      check("w_long", bus4.fetch_long, 1);
      check("w_pc", bus4.fetch_pc, 15);
      step();
      check("w_next_addr", bus4.imem_addr, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aap_fetch.md
AAP_FETCH -- requirements
Module: aap_fetch

Interface
REQ-001 Parameter PC_W, default 16: instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 imem_rd  out  1  read strobe to instruction memory.
REQ-006 imem_addr  out  PC_W  word address presented with imem_rd.
REQ-007 imem_rdata  in  16  read data; valid the cycle after imem_rd=1 (synchronous RAM, 1-cycle latency).
REQ-008 branch_valid  in  1  redirect request, one-cycle pulse.
REQ-009 branch_target  in  PC_W  redirect word address, sampled when branch_valid=1.
REQ-010 dec_ready  in  1  decoder accepts the offered instruction.
REQ-011 fetch_valid  out  1  fetchoutput/fetch_pc/fetch_long hold a valid instruction.
REQ-012 fetchoutput  out  32  instruction; [15:0] first word, [31:16] second word (zero for 16-bit).
REQ-013 fetch_pc  out  PC_W  address of the instruction's first word.
REQ-014 fetch_long  out  1  1 = 32-bit instruction.

Function
REQ-015 FSM states: S_IDLE, S_REQ, S_LO, S_HI, S_OUT.
REQ-016 S_IDLE: imem_rd=0; next S_REQ unconditionally.
REQ-017 S_REQ: imem_rd=1, imem_addr=pc; next S_LO.
REQ-018 S_LO: capture imem_rdata into fetchoutput[15:0]; if imem_rdata[15]=1, drive imem_rd=1, imem_addr=pc+1 in the same cycle, next S_HI; else clear fetchoutput[31:16], next S_OUT.
REQ-019 S_HI: capture imem_rdata into fetchoutput[31:16]; next S_OUT.
REQ-020 S_OUT: fetch_valid=1; outputs stable until handshake; on dec_ready=1, pc += 1 (16-bit) or 2 (32-bit), next S_REQ.
REQ-021 fetch_valid, fetchoutput, fetch_pc, fetch_long are registered; fetch_valid=1 only in S_OUT.
REQ-022 Latency: 16-bit instruction valid 2 cycles after S_REQ; 32-bit valid 3 cycles after S_REQ.
REQ-023 pc arithmetic modulo 2^PC_W; 32-bit instruction at address 2^PC_W-1 fetches its second word from address 0; next pc is 1.
REQ-024 branch_valid=1 in any state except S_IDLE: pc <= branch_target, next state S_REQ, in-flight read data discarded, fetch_valid=0 next cycle.
REQ-025 branch_valid and dec_ready both 1 in S_OUT: branch wins; offered instruction counts as dropped; pc = branch_target (no increment).
REQ-026 branch_valid in S_IDLE: pc <= branch_target; next state S_REQ.
REQ-027 imem_rd=0 in S_IDLE, S_HI, S_OUT; no more than one outstanding read.
REQ-028 dec_ready ignored outside S_OUT.

Reset
REQ-029 While reset=0: state S_IDLE, pc=RESET_PC, fetch_valid=0, fetchoutput=0, fetch_pc=0, fetch_long=0, imem_rd=0, imem_addr=0.
REQ-030 Reset asserted mid-fetch aborts immediately; pending read data discarded; first read after release addresses RESET_PC, issued in the second cycle after release.

Structure
REQ-031 Package aap_pkg holds: FSM state enum, PC_W default, RESET_PC default, INSN_LONG_BIT=15.
REQ-032 Single module, no sub-modules; bench uses a separate 1-cycle-latency memory model aap_imem_model.

Verification
REQ-033 Reset release, mem[0]=16'h0123, dec_ready=1 -> imem_rd at addr 0 in cycle 2, fetch_valid cycle 4, fetchoutput=32'h0000_0123, fetch_long=0, fetch_pc=0.
REQ-034 mem[1]=16'h8A00, mem[2]=16'h1234 -> fetchoutput=32'h1234_8A00, fetch_long=1, fetch_pc=1; next fetch at addr 3.
REQ-035 Hold dec_ready=0 for 5 cycles in S_OUT -> outputs unchanged, no imem_rd; dec_ready=1 -> next read issued the following cycle.
REQ-036 branch_valid=1, target 16'h0040, while in S_HI -> captured word discarded, next imem_addr=16'h0040, no instruction from old stream.
REQ-037 PC_W=4, pc=15, mem[15]=16'h8001, mem[0]=16'h00FF -> fetchoutput=32'h00FF_8001, next pc=1.
REQ-038 Assert reset during S_LO -> all outputs 0 same cycle; after release, first imem_addr=RESET_PC.
